// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller that drives an external 1-bit shifter.
// It feeds each result back until the requested count is reached.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] sh_in,
    output logic [1:0]       sh_code,
    input  logic [WIDTH-1:0] sh_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int CMP_W = (AMT_W > CNT_W) ? AMT_W : CNT_W;
    localparam logic [1:0] OP_PASS = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       op_q;
    logic [1:0]       op_next;
    logic [CMP_W-1:0] amount_ext;
    logic [CNT_W-1:0] amount_clamped;

    // Anything past WIDTH shifts everything out, so cap the cycle count there.
    always_comb begin
        amount_ext = CMP_W'(amount);
        if (amount_ext > CMP_W'(WIDTH)) begin
            amount_clamped = CNT_W'(WIDTH);
        end else begin
            amount_clamped = CNT_W'(amount_ext);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            op_q  <= OP_PASS;
        end else begin
            state <= state_next;
            work  <= work_next;
            cnt   <= cnt_next;
            op_q  <= op_next;
        end
    end

    always_comb begin
        state_next = state;
        work_next  = work;
        cnt_next   = cnt;
        op_next    = op_q;
        sh_code    = OP_PASS;
        case (state)
            IDLE: begin
                if (start) begin
                    work_next = din;
                    op_next   = op;
                    cnt_next  = amount_clamped;
                    if (op == OP_PASS || amount_clamped == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sh_code   = op_q;
                work_next = sh_out;
                cnt_next  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign dout  = work;
    assign sh_in = work;

endmodule
